// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader
// Program-load front end for the 8-bit CPU core. While load_mode is high the
// core is held halted and bytes strobed in on load_data are stored in a small
// byte memory. When load_mode drops, the core is released and its fetch reads
// are served from that memory.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   load_mode    async pin, 1 = load program, 0 = run
//   load_strobe  async pin, rising edge writes load_data
//   load_data    program byte, held stable by the host around the strobe
//   load_ack     one-cycle pulse per accepted byte
//   overflow     sticky, a write was attempted with the memory full
//   byte_count   bytes accepted in the current load
//   cpu_run      1 = core may execute
//   rd_addr      core fetch address
//   rd_data      registered fetch data (1-cycle latency, read-before-write)
//   checksum     XOR of accepted bytes when LOADER_CHECKSUM_EN is defined,
//                otherwise tied to 0
//
// Build option: define LOADER_CHECKSUM_EN to build the checksum register.
//
// state | meaning
// IDLE  | after reset, decides LOAD or RUN on the next cycle
// LOAD  | core halted, strobed bytes are written to memory
// RUN   | core released, strobes ignored
module cpu_prog_loader #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_mode,
    input  logic              load_strobe,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ack,
    output logic              overflow,
    output logic [ADDR_W:0]   byte_count,
    output logic              cpu_run,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] checksum
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [SYNC_STAGES-1:0] mode_sync_q, mode_sync_d;
    logic [SYNC_STAGES-1:0] strb_sync_q, strb_sync_d;
    logic                   strb_prev_q, strb_prev_d;
    logic                   wr_pend_q, wr_pend_d;
    logic [1:0]             state_q, state_d;
    logic [ADDR_W:0]        byte_count_q, byte_count_d;
    logic                   overflow_q, overflow_d;
    logic                   load_ack_q, load_ack_d;
    logic                   cpu_run_q, cpu_run_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [DATA_W-1:0]      mem_d [DEPTH];

    logic mode_synced;
    logic strb_rise;
    logic load_entry;
    logic mem_full;
    logic wr_accept;

    assign mode_synced = mode_sync_q[SYNC_STAGES-1];
    assign strb_rise   = strb_sync_q[SYNC_STAGES-1] & ~strb_prev_q;
    assign load_entry  = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    // byte_count doubles as the write pointer; its MSB marks a full memory
    // so the pointer never wraps.
    assign mem_full    = byte_count_q[ADDR_W];
    assign wr_accept   = wr_pend_q && !mem_full && !load_entry;

    always_comb begin
        mode_sync_d = {mode_sync_q[SYNC_STAGES-2:0], load_mode};
        strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], load_strobe};
        strb_prev_d = strb_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = mode_synced ? ST_LOAD : ST_RUN;
            ST_LOAD: if (!mode_synced) state_d = ST_RUN;
            ST_RUN:  if (mode_synced)  state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // The strobe is qualified by the state at detection time, so a write
    // detected on the cycle load_mode falls still completes after the move
    // to RUN.
    always_comb begin
        wr_pend_d    = strb_rise && (state_q == ST_LOAD);
        byte_count_d = byte_count_q;
        overflow_d   = overflow_q;
        load_ack_d   = 1'b0;
        mem_d        = mem_q;
        if (load_entry) begin
            byte_count_d = '0;
            overflow_d   = 1'b0;
        end else if (wr_pend_q) begin
            if (mem_full) begin
                overflow_d = 1'b1;
            end else begin
                mem_d[byte_count_q[ADDR_W-1:0]] = load_data;
                byte_count_d = byte_count_q + {{ADDR_W{1'b0}}, 1'b1};
                load_ack_d   = 1'b1;
            end
        end
        cpu_run_d = (state_q == ST_RUN);
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync_q  <= '0;
            strb_sync_q  <= '0;
            strb_prev_q  <= 1'b0;
            wr_pend_q    <= 1'b0;
            state_q      <= ST_IDLE;
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            load_ack_q   <= 1'b0;
            cpu_run_q    <= 1'b0;
            rd_data_q    <= '0;
            mem_q        <= '{default: '0};
        end else begin
            mode_sync_q  <= mode_sync_d;
            strb_sync_q  <= strb_sync_d;
            strb_prev_q  <= strb_prev_d;
            wr_pend_q    <= wr_pend_d;
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            overflow_q   <= overflow_d;
            load_ack_q   <= load_ack_d;
            cpu_run_q    <= cpu_run_d;
            rd_data_q    <= rd_data_d;
            mem_q        <= mem_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_entry) begin
            checksum_d = '0;
        end else if (wr_accept) begin
            checksum_d = checksum_q ^ load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_accept;
    assign unused_accept = wr_accept;
    assign checksum      = '0;
`endif

    assign load_ack   = load_ack_q;
    assign overflow   = overflow_q;
    assign byte_count = byte_count_q;
    assign cpu_run    = cpu_run_q;
    assign rd_data    = rd_data_q;

endmodule
